// File: rtl/mul_seq_ctrl.sv
// RV32M multiply sequencer: radix-2 shift-add over DATA_W cycles,
// holding the pipeline while it runs and writing back through a reg-file port.
module mul_seq_ctrl #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [2:0]         funct3_i,
   input  logic [DATA_W-1:0]  op1_i,
   input  logic [DATA_W-1:0]  op2_i,
   input  logic               reg_we_i,
   input  logic [RADDR_W-1:0] reg_waddr_i,
   input  logic               flush_i,
   output logic               stall_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               reg_we_o,
   output logic [RADDR_W-1:0] reg_waddr_o,
   output logic [DATA_W-1:0]  reg_wdata_o
);

   localparam int CW = $clog2(DATA_W);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] CALC = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]          state;
   logic [2:0]          fn;
   logic                we;
   logic [RADDR_W-1:0]  waddr;
   logic                neg;
   logic [DATA_W-1:0]   mcand;
   logic [DATA_W-1:0]   mplier;
   logic [DATA_W-1:0]   acc_hi;
   logic [CW-1:0]       cnt;
   logic                done_q;
   logic                we_q;
   logic [RADDR_W-1:0]  waddr_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                sign1;
   logic                sign2;
   logic                neg1;
   logic                neg2;
   logic [DATA_W-1:0]   mag1;
   logic [DATA_W-1:0]   mag2;
   logic                accept;
   logic                zero_op;
   logic [DATA_W:0]     sum;
   logic [DATA_W-1:0]   acc_nx;
   logic [DATA_W-1:0]   mpl_nx;
   logic [2*DATA_W-1:0] prod_raw;
   logic [2*DATA_W-1:0] prod;
   logic [DATA_W-1:0]   res;
   logic                last;

   assign sign1   = (funct3_i == 3'b001) || (funct3_i == 3'b010);
   assign sign2   = (funct3_i == 3'b001);
   assign neg1    = sign1 & op1_i[DATA_W-1];
   assign neg2    = sign2 & op2_i[DATA_W-1];
   assign mag1    = neg1 ? -op1_i : op1_i;
   assign mag2    = neg2 ? -op2_i : op2_i;
   assign accept  = (state == IDLE) & start_i & ~funct3_i[2] & ~flush_i;
   assign zero_op = (op1_i == '0) || (op2_i == '0);

   // One shift-add step; the carry out re-enters as the new MSB of acc_hi.
   assign sum      = {1'b0, acc_hi} + ({1'b0, mcand} & {(DATA_W+1){mplier[0]}});
   assign acc_nx   = sum[DATA_W:1];
   assign mpl_nx   = {sum[0], mplier[DATA_W-1:1]};
   assign prod_raw = {acc_nx, mpl_nx};
   assign prod     = neg ? -prod_raw : prod_raw;
   assign res      = (fn == 3'b000) ? prod[DATA_W-1:0] : prod[2*DATA_W-1:DATA_W];
   assign last     = (cnt == CW'(DATA_W - 1));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= IDLE;
         fn      <= '0;
         we      <= 1'b0;
         waddr   <= '0;
         neg     <= 1'b0;
         mcand   <= '0;
         mplier  <= '0;
         acc_hi  <= '0;
         cnt     <= '0;
         done_q  <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  fn     <= funct3_i;
                  we     <= reg_we_i;
                  waddr  <= reg_waddr_i;
                  neg    <= neg1 ^ neg2;
                  mcand  <= mag1;
                  mplier <= mag2;
                  acc_hi <= '0;
                  cnt    <= '0;
                  if (zero_op) begin
                     state   <= DONE;
                     done_q  <= 1'b1;
                     we_q    <= reg_we_i & (reg_waddr_i != '0);
                     waddr_q <= reg_waddr_i;
                     wdata_q <= '0;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (flush_i) begin
                  state <= IDLE;
               end else begin
                  acc_hi <= acc_nx;
                  mplier <= mpl_nx;
                  cnt    <= cnt + CW'(1);
                  if (last) begin
                     state   <= DONE;
                     done_q  <= 1'b1;
                     we_q    <= we & (waddr != '0);
                     waddr_q <= waddr;
                     wdata_q <= res;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               done_q  <= 1'b0;
               we_q    <= 1'b0;
               waddr_q <= '0;
               wdata_q <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign stall_o     = accept | (state == CALC);
   assign busy_o      = (state != IDLE);
   assign done_o      = done_q & ~flush_i;
   assign reg_we_o    = we_q & ~flush_i;
   assign reg_waddr_o = waddr_q;
   assign reg_wdata_o = wdata_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Bench for mul_seq_ctrl: directed timing scenarios plus random ops
// checked against a 64-bit arithmetic reference.
module tb_mul_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic [2:0]  funct3_i;
   logic [31:0] op1_i;
   logic [31:0] op2_i;
   logic        reg_we_i;
   logic [4:0]  reg_waddr_i;
   logic        flush_i;
   logic        stall_o;
   logic        busy_o;
   logic        done_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mul_seq_ctrl #(.DATA_W(32), .RADDR_W(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .start_i     (start_i),
      .funct3_i    (funct3_i),
      .op1_i       (op1_i),
      .op2_i       (op2_i),
      .reg_we_i    (reg_we_i),
      .reg_waddr_i (reg_waddr_i),
      .flush_i     (flush_i),
      .stall_o     (stall_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .reg_we_o    (reg_we_o),
      .reg_waddr_o (reg_waddr_o),
      .reg_wdata_o (reg_wdata_o)
   );

   function automatic logic [31:0] ref_mul(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic we,
                         input logic [4:0] wa, output int lat,
                         output logic [31:0] d, output logic [4:0] ad,
                         output logic wo);
      lat = -1; d = '0; ad = '0; wo = 1'b0;
      @(negedge clk);
      start_i = 1'b1; funct3_i = f3; op1_i = a; op2_i = b;
      reg_we_i = we; reg_waddr_i = wa;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         if (done_o) begin
            lat = c; d = reg_wdata_o; ad = reg_waddr_o; wo = reg_we_o;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; funct3_i = '0;
      op1_i = '0; op2_i = '0; reg_we_i = 1'b0; reg_waddr_i = '0;
      repeat (3) @(negedge clk);
      rst_i = 1'b0;
      #1;
      checks++;
      if ({busy_o, done_o, reg_we_o, stall_o} !== 4'b0)
         $display("FAIL reset_flags: got %b expected 0000",
                  {busy_o, done_o, reg_we_o, stall_o});
      checks++;
      if (reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0)
         $display("FAIL reset_data: got %h/%h expected 0/0",
                  reg_waddr_o, reg_wdata_o);
      if ({busy_o, done_o, reg_we_o, stall_o} !== 4'b0) errors++;
      if (reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0) errors++;
   endtask

   task automatic test_mul_timing();
      logic eb, es, ed;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd7; op2_i = 32'd6;
      reg_we_i = 1'b1; reg_waddr_i = 5'd5;
      #1;
      checks++;
      if (stall_o !== 1'b1) begin
         errors++;
         $display("FAIL t1_stall_c0: got %b expected 1", stall_o);
      end
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         eb = (c <= 33); es = (c <= 32); ed = (c == 33);
         checks++;
         if (busy_o !== eb) begin
            errors++;
            $display("FAIL t1_busy c%0d: got %b expected %b", c, busy_o, eb);
         end
         checks++;
         if (stall_o !== es) begin
            errors++;
            $display("FAIL t1_stall c%0d: got %b expected %b", c, stall_o, es);
         end
         checks++;
         if (done_o !== ed || reg_we_o !== ed) begin
            errors++;
            $display("FAIL t1_done c%0d: got %b%b expected %b%b",
                     c, done_o, reg_we_o, ed, ed);
         end
         checks++;
         if (reg_wdata_o !== (ed ? 32'd42 : 32'd0) ||
             reg_waddr_o !== (ed ? 5'd5 : 5'd0)) begin
            errors++;
            $display("FAIL t1_data c%0d: got %h@%0d", c, reg_wdata_o, reg_waddr_o);
         end
      end
   endtask

   task automatic test_vectors();
      logic [2:0]  f3 [7] = '{3'b000, 3'b001, 3'b011, 3'b010,
                              3'b001, 3'b010, 3'b000};
      logic [31:0] va [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFE,
                              32'h12345678};
      logic [31:0] vb [7] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'h80000000, 32'h00000003,
                              32'h9ABCDEF0};
      logic [31:0] ve [7] = '{32'h00000001, 32'h00000000, 32'hFFFFFFFE,
                              32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF,
                              32'h242D2080};
      int lat;
      logic [31:0] d;
      logic [4:0] ad;
      logic wo;
      for (int i = 0; i < 7; i++) begin
         run_op(f3[i], va[i], vb[i], 1'b1, 5'd9, lat, d, ad, wo);
         checks++;
         if (d !== ve[i] || lat != 33 || wo !== 1'b1) begin
            errors++;
            $display("FAIL vec%0d: got %h lat %0d we %b expected %h lat 33 we 1",
                     i, d, lat, wo, ve[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat, elat;
      logic [31:0] a, b, d, exp_d;
      logic [4:0] wa, ad;
      logic we, wo, exp_we;
      logic [2:0] f3;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 7))
            0: a = 32'h0;
            1: a = 32'h80000000;
            2: a = 32'hFFFFFFFF;
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = 32'h80000000;
            2: b = 32'hFFFFFFFF;
            default: b = $urandom;
         endcase
         f3 = 3'($urandom_range(0, 3));
         wa = 5'($urandom_range(0, 31));
         we = 1'($urandom_range(0, 1));
         exp_d  = ref_mul(f3, a, b);
         exp_we = we && (wa != 5'd0);
         elat   = (a == 32'h0 || b == 32'h0) ? 1 : 33;
         run_op(f3, a, b, we, wa, lat, d, ad, wo);
         checks++;
         if (d !== exp_d || lat != elat || wo !== exp_we || ad !== wa) begin
            errors++;
            $display("FAIL rand%0d f3=%0d %h*%h: got %h lat %0d we %b a %0d expected %h lat %0d we %b a %0d",
                     i, f3, a, b, d, lat, wo, ad, exp_d, elat, exp_we, wa);
         end
      end
   endtask

   task automatic test_fast_and_div();
      int lat;
      logic [31:0] d;
      logic [4:0] ad;
      logic wo;
      run_op(3'b000, 32'h1234, 32'h0, 1'b1, 5'd4, lat, d, ad, wo);
      checks++;
      if (lat != 1 || d !== 32'h0 || busy_o !== 1'b1 || wo !== 1'b1) begin
         errors++;
         $display("FAIL fast_path: got lat %0d data %h busy %b we %b expected 1/0/1/1",
                  lat, d, busy_o, wo);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL fast_busy_c2: got %b expected 0", busy_o);
      end
      start_i = 1'b1; funct3_i = 3'b100; op1_i = 32'd100; op2_i = 32'd7;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++;
         $display("FAIL div_stall: got %b expected 0", stall_o);
      end
      repeat (3) begin
         @(negedge clk);
         #1;
         checks++;
         if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL div_busy: got %b%b expected 00", busy_o, done_o);
         end
      end
      start_i = 1'b0;
   endtask

   task automatic test_flush();
      int dc;
      logic [31:0] dd;
      int lat;
      logic [31:0] d;
      logic [4:0] ad;
      logic wo;
      logic seen_we;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd5; op2_i = 32'd7;
      reg_we_i = 1'b1; reg_waddr_i = 5'd3;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      flush_i = 1'b1;
      #1;
      checks++;
      if (busy_o !== 1'b1 || done_o !== 1'b0 || reg_we_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_c10: got busy %b done %b we %b expected 1/0/0",
                  busy_o, done_o, reg_we_o);
      end
      @(negedge clk);
      flush_i = 1'b0;
      start_i = 1'b1; op1_i = 32'd3; op2_i = 32'd3; reg_waddr_i = 5'd7;
      #1;
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_c11: got busy %b stall %b expected 0/1",
                  busy_o, stall_o);
      end
      dc = -1; dd = '0; seen_we = 1'b0;
      for (int c = 12; c <= 50; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         if (done_o && dc < 0) begin
            dc = c; dd = reg_wdata_o; seen_we = reg_we_o;
         end
      end
      checks++;
      if (dc != 44 || dd !== 32'd9 || seen_we !== 1'b1) begin
         errors++;
         $display("FAIL flush_restart: got done c%0d data %h we %b expected c44 data 9 we 1",
                  dc, dd, seen_we);
      end
      run_op(3'b011, 32'd11, 32'd13, 1'b1, 5'd2, lat, d, ad, wo);
      flush_i = 1'b1;
      #1;
      checks++;
      if (lat != 33 || done_o !== 1'b0 || reg_we_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_done: got lat %0d done %b we %b expected 33/0/0",
                  lat, done_o, reg_we_o);
      end
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd2; op2_i = 32'd2;
      #1;
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_start_idle: got busy %b stall %b expected 0/0",
                  busy_o, stall_o);
      end
      @(negedge clk);
      start_i = 1'b0; flush_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL flush_wins: got busy %b expected 0", busy_o);
      end
   endtask

   task automatic test_reset_mid();
      int ndone;
      int lat;
      logic [31:0] d;
      logic [4:0] ad;
      logic wo;
      @(negedge clk);
      start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd9; op2_i = 32'd9;
      reg_we_i = 1'b1; reg_waddr_i = 5'd6;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         start_i = 1'b0;
      end
      rst_i = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if ({busy_o, done_o, reg_we_o} !== 3'b0 || reg_wdata_o !== 32'd0 ||
          reg_waddr_o !== 5'd0) begin
         errors++;
         $display("FAIL rst_mid: got %b %h %0d expected 000 0 0",
                  {busy_o, done_o, reg_we_o}, reg_wdata_o, reg_waddr_o);
      end
      rst_i = 1'b0;
      ndone = 0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (done_o || reg_we_o) ndone++;
      end
      checks++;
      if (ndone != 0) begin
         errors++;
         $display("FAIL rst_no_write: got %0d done cycles expected 0", ndone);
      end
      run_op(3'b000, 32'h11, 32'h22, 1'b1, 5'd0, lat, d, ad, wo);
      checks++;
      if (lat != 33 || wo !== 1'b0 || d !== 32'h242) begin
         errors++;
         $display("FAIL waddr0: got lat %0d we %b data %h expected 33/0/242",
                  lat, wo, d);
      end
   endtask

   task automatic test_back_to_back();
      int lat, dc;
      logic [31:0] d, dd;
      logic [4:0] ad;
      logic wo;
      run_op(3'b000, 32'd100, 32'd200, 1'b1, 5'd8, lat, d, ad, wo);
      start_i = 1'b1; funct3_i = 3'b000; op1_i = 32'd2; op2_i = 32'd5;
      reg_we_i = 1'b1; reg_waddr_i = 5'd10;
      @(negedge clk);
      #1;
      checks++;
      if (d !== 32'd20000 || busy_o !== 1'b0 || stall_o !== 1'b1) begin
         errors++;
         $display("FAIL b2b_idle: got data %0d busy %b stall %b expected 20000/0/1",
                  d, busy_o, stall_o);
      end
      dc = -1; dd = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start_i = 1'b0;
         #1;
         if (done_o && dc < 0) begin
            dc = c; dd = reg_wdata_o;
         end
      end
      checks++;
      if (dc != 33 || dd !== 32'd10) begin
         errors++;
         $display("FAIL b2b_second: got c%0d data %0d expected c33 data 10", dc, dd);
      end
   endtask

   initial begin
      test_reset();
      test_mul_timing();
      test_vectors();
      test_fast_and_div();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
